program_loader: RTL

- Byte-stream boot loader that fills the CPU's instruction memory before execution starts.
- Accepts a framed byte stream (length, halfword payload, checksum) over a valid/ready handshake, typically from a UART receiver.
- Drives the CPU's program-memory write port: write enable, 16-bit instruction and address.
- Holds the CPU in reset until a load completes with a good checksum, then releases it.

---
 rtl/program_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Purpose : byte-stream boot loader; parses {LEN_LO, LEN_HI, N x (DATA_LO, DATA_HI), CHK}
//           and writes each halfword into CPU program memory, holding the CPU in reset until
//           a frame completes with a good checksum.
// Latency : write strobe 1 cycle after the DATA_HI transfer (max 1 halfword / 3 cycles);
//           cpu_reset_o drops 1 cycle after a matching CHK transfer.
// Backpressure: byte_ready_o is a pure function of state (high only in LEN_LO, LEN_HI,
//           DATA_LO, DATA_HI, CHK); the loader waits indefinitely for byte_valid_i.
//
// Ports:
//   clk_i, reset_i           clock, synchronous active-low reset
//   start_i                  begin a load (honoured in IDLE, DONE, ERROR only)
//   byte_i/_valid_i/_ready_o incoming framed byte stream, valid/ready handshake
//   program_mem_write_en_o   one-cycle write strobe per halfword
//   instruction_o            halfword being written
//   instruction_addr_o       write address (BASE_ADDR + k*ADDR_STEP, wraps mod 2^32)
//   cpu_reset_o              active-high CPU reset, low only in DONE
//   done_o / error_o         levels: good load / bad checksum or oversize length
module program_loader #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter logic [31:0] ADDR_STEP     = 32'd2,
  parameter int unsigned MAX_HALFWORDS = 1024
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        program_mem_write_en_o,
  output logic [15:0] instruction_o,
  output logic [31:0] instruction_addr_o,
  output logic        cpu_reset_o,
  output logic        done_o,
  output logic        error_o
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;   // halfwords still to be written
  logic [7:0]  lo_q, lo_d;         // low byte latch, shared by length and data phases
  logic [7:0]  chk_q, chk_d;       // running XOR of payload bytes
  logic [15:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;

  logic        xfer;
  logic [15:0] len_w;

  assign xfer  = byte_valid_i & byte_ready_o;
  assign len_w = {byte_i, lo_q};

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      count_q <= 16'd0;
      lo_q    <= 8'd0;
      chk_q   <= 8'd0;
      instr_q <= 16'd0;
      addr_q  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lo_q    <= lo_d;
      chk_q   <= chk_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    count_d                = count_q;
    lo_d                   = lo_q;
    chk_d                  = chk_q;
    instr_d                = instr_q;
    addr_d                 = addr_q;
    byte_ready_o           = 1'b0;
    program_mem_write_en_o = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          addr_d  = BASE_ADDR;
          chk_d   = 8'd0;
          count_d = 16'd0;
          state_d = ST_LEN_LO;
        end
      end

      ST_LEN_LO: begin
        byte_ready_o = 1'b1;
        if (xfer) begin
          lo_d    = byte_i;
          state_d = ST_LEN_HI;
        end
      end

      ST_LEN_HI: begin
        byte_ready_o = 1'b1;
        if (xfer) begin
          count_d = len_w;
          if (32'(len_w) > MAX_HALFWORDS) begin
            state_d = ST_ERROR;
          end else if (len_w == 16'd0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_DATA_LO;
          end
        end
      end

      ST_DATA_LO: begin
        byte_ready_o = 1'b1;
        if (xfer) begin
          lo_d    = byte_i;
          chk_d   = chk_q ^ byte_i;
          state_d = ST_DATA_HI;
        end
      end

      ST_DATA_HI: begin
        byte_ready_o = 1'b1;
        if (xfer) begin
          instr_d = {byte_i, lo_q};
          chk_d   = chk_q ^ byte_i;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // Address and data are held for the strobe cycle; the address steps on exit
        // so the next halfword sees the advanced value.
        program_mem_write_en_o = 1'b1;
        addr_d                 = addr_q + ADDR_STEP;
        count_d                = count_q - 16'd1;
        state_d                = (count_q == 16'd1) ? ST_CHK : ST_DATA_LO;
      end

      ST_CHK: begin
        byte_ready_o = 1'b1;
        if (xfer) begin
          state_d = (byte_i == chk_q) ? ST_DONE : ST_ERROR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign instruction_o      = instr_q;
  assign instruction_addr_o = addr_q;
  assign done_o             = (state_q == ST_DONE);
  assign error_o            = (state_q == ST_ERROR);
  // The CPU runs only once a frame has verified.
  assign cpu_reset_o        = (state_q != ST_DONE);

endmodule
